// File: rtl/decode_stage.sv
// Instruction Decode stage: register file with write-first bypass, load-use
// hazard detection, ID/EX pipeline register and a saturating stall counter.
module decode_stage #(
  parameter int         DATA_WIDTH  = 16,
  parameter int         NUM_REGS    = 32,
  parameter logic [4:0] LOAD_OPCODE = 5'b00110
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  input  logic [DATA_WIDTH-1:0] npc_in,
  input  logic                  flush,
  input  logic                  wb_en,
  input  logic [4:0]            wb_index,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [4:0]            control_out,
  output logic [4:0]            dest_index_out,
  output logic [DATA_WIDTH-1:0] reg1_data,
  output logic [DATA_WIDTH-1:0] reg2_data,
  output logic [DATA_WIDTH-1:0] npc_out,
  output logic [6:0]            immediate,
  output logic                  out_valid,
  output logic                  reg_write_en,
  output logic [15:0]           stall_count
);

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b00001;
  localparam logic [4:0] OP_ADD   = 5'b00010;
  localparam logic [4:0] OP_AND   = 5'b00011;
  localparam logic [4:0] OP_OR    = 5'b00100;
  localparam logic [4:0] OP_STORE = 5'b00111;
  localparam logic [4:0] OP_BEQ   = 5'b01000;
  localparam logic [4:0] OP_JMP   = 5'b01001;

  logic [4:0] opcode, rd, rs1, rs2;
  logic [6:0] imm7;
  logic       op_defined, uses_rs1, uses_rs2, writes_rd, hazard;
  logic [DATA_WIDTH-1:0] rs1_val, rs2_val;

  assign opcode = instr[31:27];
  assign rd     = instr[26:22];
  assign rs1    = instr[21:17];
  assign rs2    = instr[16:12];
  assign imm7   = instr[6:0];

  // R0 has no storage; every other register clears on reset.
  logic [DATA_WIDTH-1:0] rf_reg [1:NUM_REGS-1];

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_rf
      always_ff @(posedge clk) begin
        if (reset) begin
          rf_reg[gi] <= '0;
        end else if (wb_en && (wb_index == 5'(gi))) begin
          rf_reg[gi] <= wb_data;
        end
      end
    end
  endgenerate

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0) rs1_val = (wb_en && wb_index == rs1) ? wb_data : rf_reg[rs1];
    if (rs2 != 5'd0) rs2_val = (wb_en && wb_index == rs2) ? wb_data : rf_reg[rs2];
  end

  assign op_defined = (opcode <= OP_JMP);
  assign uses_rs1   = op_defined && (opcode != OP_NOP) && (opcode != OP_JMP);
  assign uses_rs2   = (opcode == OP_SUB) || (opcode == OP_ADD) || (opcode == OP_AND) ||
                      (opcode == OP_OR)  || (opcode == OP_STORE) || (opcode == OP_BEQ);
  assign writes_rd  = (opcode >= OP_SUB) && (opcode <= LOAD_OPCODE) && (rd != 5'd0);

  logic [4:0]            control_reg, control_next;
  logic [4:0]            dest_reg, dest_next;
  logic [DATA_WIDTH-1:0] reg1_reg, reg1_next;
  logic [DATA_WIDTH-1:0] reg2_reg, reg2_next;
  logic [DATA_WIDTH-1:0] npc_reg, npc_next;
  logic [6:0]            imm_reg, imm_next;
  logic                  valid_reg, valid_next;
  logic                  we_reg, we_next;
  logic [15:0]           stall_reg;

  // A load in ID/EX cannot forward its result to an instruction that reads rd.
  assign hazard = in_valid && valid_reg && (control_reg == LOAD_OPCODE) && (dest_reg != 5'd0) &&
                  ((uses_rs1 && rs1 == dest_reg) || (uses_rs2 && rs2 == dest_reg));
  assign in_ready = !hazard || flush;

  always_comb begin
    control_next = '0;
    dest_next    = '0;
    reg1_next    = '0;
    reg2_next    = '0;
    npc_next     = '0;
    imm_next     = '0;
    valid_next   = 1'b0;
    we_next      = 1'b0;
    if (!flush && !hazard && in_valid && op_defined) begin
      control_next = opcode;
      dest_next    = rd;
      reg1_next    = rs1_val;
      reg2_next    = rs2_val;
      npc_next     = npc_in;
      imm_next     = imm7;
      valid_next   = 1'b1;
      we_next      = writes_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      control_reg <= '0;
      dest_reg    <= '0;
      reg1_reg    <= '0;
      reg2_reg    <= '0;
      npc_reg     <= '0;
      imm_reg     <= '0;
      valid_reg   <= 1'b0;
      we_reg      <= 1'b0;
      stall_reg   <= '0;
    end else begin
      control_reg <= control_next;
      dest_reg    <= dest_next;
      reg1_reg    <= reg1_next;
      reg2_reg    <= reg2_next;
      npc_reg     <= npc_next;
      imm_reg     <= imm_next;
      valid_reg   <= valid_next;
      we_reg      <= we_next;
      if (hazard && !flush && (stall_reg != 16'hFFFF)) stall_reg <= stall_reg + 16'd1;
    end
  end

  assign control_out    = control_reg;
  assign dest_index_out = dest_reg;
  assign reg1_data      = reg1_reg;
  assign reg2_data      = reg2_reg;
  assign npc_out        = npc_reg;
  assign immediate      = imm_reg;
  assign out_valid      = valid_reg;
  assign reg_write_en   = we_reg;
  assign stall_count    = stall_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: scenario tasks push the expected ID/EX
// contents for each edge; a monitor pops and compares them after the edge.
module tb_decode_stage;

  localparam logic [4:0] ADD = 5'b00010, SUB = 5'b00001, OR_ = 5'b00100, LOAD = 5'b00110,
                         STORE = 5'b00111, JMP = 5'b01001, UNDEF = 5'b11111;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, flush, wb_en;
  logic [31:0] instr;
  logic [15:0] npc_in, wb_data;
  logic [4:0]  wb_index;
  logic [4:0]  control_out, dest_index_out;
  logic [15:0] reg1_data, reg2_data, npc_out, stall_count;
  logic [6:0]  immediate;
  logic        out_valid, reg_write_en;

  decode_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .npc_in(npc_in), .flush(flush), .wb_en(wb_en), .wb_index(wb_index), .wb_data(wb_data),
    .control_out(control_out), .dest_index_out(dest_index_out), .reg1_data(reg1_data),
    .reg2_data(reg2_data), .npc_out(npc_out), .immediate(immediate), .out_valid(out_valid),
    .reg_write_en(reg_write_en), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  ctrl;
    logic [4:0]  dest;
    logic [15:0] r1;
    logic [15:0] r2;
    logic [15:0] npc;
    logic [6:0]  imm;
    logic        valid;
    logic        we;
    logic [15:0] stall;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int txn = 0;

  function automatic exp_t mk_exp(input logic [4:0] c, input logic [4:0] d, input logic [15:0] a,
                                  input logic [15:0] b, input logic [15:0] n, input logic [6:0] im,
                                  input logic v, input logic w, input logic [15:0] s);
    exp_t e;
    e.ctrl = c; e.dest = d; e.r1 = a; e.r2 = b; e.npc = n; e.imm = im;
    e.valid = v; e.we = w; e.stall = s;
    return e;
  endfunction

  function automatic exp_t bubble(input logic [15:0] s);
    return mk_exp(5'd0, 5'd0, 16'd0, 16'd0, 16'd0, 7'd0, 1'b0, 1'b0, s);
  endfunction

  function automatic logic [31:0] mk_instr(input logic [4:0] op, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [6:0] imm);
    return {op, rd, rs1, rs2, 5'd0, imm};
  endfunction

  task automatic set_in(input logic v, input logic [31:0] ins, input logic [15:0] npc,
                        input logic fl, input logic we, input logic [4:0] wi, input logic [15:0] wd);
    in_valid = v; instr = ins; npc_in = npc; flush = fl;
    wb_en = we; wb_index = wi; wb_data = wd;
  endtask

  // Inputs change at posedge+2, the monitor samples at posedge+1.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      txn++;
      checks++;
      if ({control_out, dest_index_out, out_valid, reg_write_en} !== {e.ctrl, e.dest, e.valid, e.we}) begin
        errors++;
        $display("FAIL txn %0d ctrl/dest/valid/we: got %h/%0d/%b/%b expected %h/%0d/%b/%b", txn,
                 control_out, dest_index_out, out_valid, reg_write_en, e.ctrl, e.dest, e.valid, e.we);
      end
      checks++;
      if ({reg1_data, reg2_data} !== {e.r1, e.r2}) begin
        errors++;
        $display("FAIL txn %0d operands: got %h/%h expected %h/%h", txn, reg1_data, reg2_data, e.r1, e.r2);
      end
      checks++;
      if ({npc_out, immediate} !== {e.npc, e.imm}) begin
        errors++;
        $display("FAIL txn %0d npc/imm: got %h/%h expected %h/%h", txn, npc_out, immediate, e.npc, e.imm);
      end
      checks++;
      if (stall_count !== e.stall) begin
        errors++;
        $display("FAIL txn %0d stall_count: got %0d expected %0d", txn, stall_count, e.stall);
      end
      $display("txn %0d: ctrl=%h dest=%0d r1=%h r2=%h npc=%h imm=%h valid=%b we=%b stall=%0d",
               txn, control_out, dest_index_out, reg1_data, reg2_data, npc_out, immediate,
               out_valid, reg_write_en, stall_count);
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    set_in(1'b1, mk_instr(ADD, 5'd2, 5'd0, 5'd0, 7'd5), 16'h1234, 1'b0, 1'b1, 5'd4, 16'hBEEF);
    exp_q.push_back(bubble(16'd0));
    tick();
    exp_q.push_back(bubble(16'd0));
    tick();
    reset = 1'b0;
    set_in(1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 5'd0, 16'd0);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_add();
    set_in(1'b1, mk_instr(ADD, 5'd2, 5'd0, 5'd0, 7'h15), 16'h0102, 1'b0, 1'b0, 5'd0, 16'd0);
    exp_q.push_back(mk_exp(ADD, 5'd2, 16'd0, 16'd0, 16'h0102, 7'h15, 1'b1, 1'b1, 16'd0));
    tick();
  endtask

  task automatic test_bypass();
    set_in(1'b0, 32'd0, 16'd0, 1'b0, 1'b1, 5'd4, 16'd3);
    exp_q.push_back(bubble(16'd0));
    tick();
    set_in(1'b1, mk_instr(SUB, 5'd2, 5'd3, 5'd4, 7'h7F), 16'h0200, 1'b0, 1'b1, 5'd3, 16'd10);
    exp_q.push_back(mk_exp(SUB, 5'd2, 16'd10, 16'd3, 16'h0200, 7'h7F, 1'b1, 1'b1, 16'd0));
    tick();
    set_in(1'b1, mk_instr(ADD, 5'd1, 5'd3, 5'd4, 7'h00), 16'h0201, 1'b0, 1'b0, 5'd0, 16'd0);
    exp_q.push_back(mk_exp(ADD, 5'd1, 16'd10, 16'd3, 16'h0201, 7'h00, 1'b1, 1'b1, 16'd0));
    tick();
  endtask

  task automatic test_load_use();
    set_in(1'b1, mk_instr(LOAD, 5'd5, 5'd3, 5'd0, 7'h04), 16'h0300, 1'b0, 1'b0, 5'd0, 16'd0);
    exp_q.push_back(mk_exp(LOAD, 5'd5, 16'd10, 16'd0, 16'h0300, 7'h04, 1'b1, 1'b1, 16'd0));
    tick();
    set_in(1'b1, mk_instr(ADD, 5'd6, 5'd5, 5'd4, 7'h00), 16'h0301, 1'b0, 1'b0, 5'd0, 16'd0);
    exp_q.push_back(bubble(16'd1));
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_use_in_ready: got %b expected 0", in_ready);
    end
    tick();
    set_in(1'b1, mk_instr(ADD, 5'd6, 5'd5, 5'd4, 7'h00), 16'h0301, 1'b0, 1'b1, 5'd5, 16'h0055);
    exp_q.push_back(mk_exp(ADD, 5'd6, 16'h0055, 16'd3, 16'h0301, 7'h00, 1'b1, 1'b1, 16'd1));
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_use_retry_in_ready: got %b expected 1", in_ready);
    end
    tick();
  endtask

  task automatic test_jmp_no_stall();
    set_in(1'b1, mk_instr(LOAD, 5'd5, 5'd0, 5'd0, 7'h00), 16'h0400, 1'b0, 1'b0, 5'd0, 16'd0);
    exp_q.push_back(mk_exp(LOAD, 5'd5, 16'd0, 16'd0, 16'h0400, 7'h00, 1'b1, 1'b1, 16'd1));
    tick();
    set_in(1'b1, mk_instr(JMP, 5'd0, 5'd5, 5'd5, 7'h22), 16'h0401, 1'b0, 1'b0, 5'd0, 16'd0);
    exp_q.push_back(mk_exp(JMP, 5'd0, 16'h0055, 16'h0055, 16'h0401, 7'h22, 1'b1, 1'b0, 16'd1));
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL jmp_in_ready: got %b expected 1", in_ready);
    end
    tick();
  endtask

  task automatic test_flush();
    set_in(1'b1, mk_instr(LOAD, 5'd5, 5'd0, 5'd0, 7'h00), 16'h0500, 1'b0, 1'b0, 5'd0, 16'd0);
    exp_q.push_back(mk_exp(LOAD, 5'd5, 16'd0, 16'd0, 16'h0500, 7'h00, 1'b1, 1'b1, 16'd1));
    tick();
    set_in(1'b1, mk_instr(ADD, 5'd6, 5'd5, 5'd0, 7'h00), 16'h0501, 1'b1, 1'b0, 5'd0, 16'd0);
    exp_q.push_back(bubble(16'd1));
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_in_ready: got %b expected 1", in_ready);
    end
    tick();
    set_in(1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 5'd0, 16'd0);
    exp_q.push_back(bubble(16'd1));
    tick();
  endtask

  task automatic test_back_to_back();
    set_in(1'b1, mk_instr(LOAD, 5'd7, 5'd4, 5'd0, 7'h01), 16'h0600, 1'b0, 1'b0, 5'd0, 16'd0);
    exp_q.push_back(mk_exp(LOAD, 5'd7, 16'd3, 16'd0, 16'h0600, 7'h01, 1'b1, 1'b1, 16'd1));
    tick();
    set_in(1'b1, mk_instr(LOAD, 5'd8, 5'd7, 5'd0, 7'h02), 16'h0601, 1'b0, 1'b0, 5'd0, 16'd0);
    exp_q.push_back(bubble(16'd2));
    tick();
    exp_q.push_back(mk_exp(LOAD, 5'd8, 16'd0, 16'd0, 16'h0601, 7'h02, 1'b1, 1'b1, 16'd2));
    tick();
    set_in(1'b1, mk_instr(OR_, 5'd9, 5'd3, 5'd4, 7'h03), 16'h0602, 1'b0, 1'b0, 5'd0, 16'd0);
    exp_q.push_back(mk_exp(OR_, 5'd9, 16'd10, 16'd3, 16'h0602, 7'h03, 1'b1, 1'b1, 16'd2));
    tick();
    set_in(1'b1, mk_instr(STORE, 5'd5, 5'd3, 5'd8, 7'h04), 16'h0603, 1'b0, 1'b0, 5'd0, 16'd0);
    exp_q.push_back(mk_exp(STORE, 5'd5, 16'd10, 16'd0, 16'h0603, 7'h04, 1'b1, 1'b0, 16'd2));
    tick();
  endtask

  task automatic test_r0_and_undefined();
    set_in(1'b0, 32'd0, 16'd0, 1'b0, 1'b1, 5'd0, 16'hFFFF);
    exp_q.push_back(bubble(16'd2));
    tick();
    set_in(1'b1, mk_instr(ADD, 5'd0, 5'd0, 5'd0, 7'h11), 16'h0700, 1'b0, 1'b1, 5'd0, 16'hFFFF);
    exp_q.push_back(mk_exp(ADD, 5'd0, 16'd0, 16'd0, 16'h0700, 7'h11, 1'b1, 1'b0, 16'd2));
    tick();
    set_in(1'b1, mk_instr(UNDEF, 5'd3, 5'd3, 5'd4, 7'h12), 16'h0701, 1'b0, 1'b0, 5'd0, 16'd0);
    exp_q.push_back(bubble(16'd2));
    tick();
  endtask

  task automatic test_reset_mid_stall();
    set_in(1'b1, mk_instr(LOAD, 5'd5, 5'd0, 5'd0, 7'h00), 16'h0800, 1'b0, 1'b0, 5'd0, 16'd0);
    exp_q.push_back(mk_exp(LOAD, 5'd5, 16'd0, 16'd0, 16'h0800, 7'h00, 1'b1, 1'b1, 16'd2));
    tick();
    reset = 1'b1;
    set_in(1'b1, mk_instr(ADD, 5'd6, 5'd5, 5'd0, 7'h00), 16'h0801, 1'b0, 1'b0, 5'd0, 16'd0);
    exp_q.push_back(bubble(16'd0));
    tick();
    reset = 1'b0;
    set_in(1'b1, mk_instr(ADD, 5'd6, 5'd3, 5'd4, 7'h05), 16'h0802, 1'b0, 1'b0, 5'd0, 16'd0);
    exp_q.push_back(mk_exp(ADD, 5'd6, 16'd0, 16'd0, 16'h0802, 7'h05, 1'b1, 1'b1, 16'd0));
    tick();
    set_in(1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 5'd0, 16'd0);
    exp_q.push_back(bubble(16'd0));
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_bypass();
    test_load_use();
    test_jmp_no_stall();
    test_flush();
    test_back_to_back();
    test_r0_and_undefined();
    test_reset_mid_stall();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction Decode stage of the 16-bit pipelined core; sits directly upstream of Execute and drives its control, operand, NPC and immediate inputs through a registered ID/EX boundary.
- Contains the 32x16 register file with the write-back port.
- Detects load-use hazards and inserts bubbles; accepts a flush from the branch-resolution logic.
- Keeps a saturating stall counter for performance debug.

Parameters:
- DATA_WIDTH, 16, width of registers, NPC and operand outputs.
- NUM_REGS, 32, register file depth; R0 is hardwired to zero.
- LOAD_OPCODE, 5'b00110, opcode that triggers load-use hazard detection.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  fetch presents a valid instruction.
- in_ready  output  1  decode accepts the instruction this cycle (combinational).
- instr  input  32  instruction word: [31:27] opcode, [26:22] rd, [21:17] rs1, [16:12] rs2, [6:0] imm7.
- npc_in  input  16  next PC accompanying instr.
- flush  input  1  discard the instruction currently being decoded.
- wb_en  input  1  register file write enable from write-back.
- wb_index  input  5  write-back destination index.
- wb_data  input  16  write-back data.
- control_out  output  5  registered opcode to Execute (0 = NOP).
- dest_index_out  output  5  registered rd.
- reg1_data  output  16  registered rs1 operand.
- reg2_data  output  16  registered rs2 operand.
- npc_out  output  16  registered NPC.
- immediate  output  7  registered imm7.
- out_valid  output  1  ID/EX register holds a real instruction.
- reg_write_en  output  1  registered instruction writes rd.
- stall_count  output  16  number of load-use stall cycles, saturating.

Behaviour:
- Opcodes: 00000 NOP, 00001 SUB, 00010 ADD, 00011 AND, 00100 OR, 00101 ADDI, 00110 LOAD, 00111 STORE, 01000 BEQ, 01001 JMP.
- Opcodes 01010 to 11111 are undefined; they decode as NOP: control 0, out_valid 0, reg_write_en 0.
- reg_write_en is 1 for opcodes 00001 to 00110 when rd != 0; otherwise 0.
- rs1 is used by every opcode except NOP and JMP. rs2 is used by SUB, ADD, AND, OR, STORE and BEQ.
- Reset (synchronous): all outputs 0, all 32 registers cleared to 0, stall_count 0. Reset overrides every other input, including in the middle of a stall.
- Register file write: on a rising edge with wb_en=1 and wb_index!=0, the register is written. Writes to R0 are ignored; reads of R0 always return 0.
- Write-first bypass: if wb_en=1 and wb_index equals a nonzero read index in the same cycle, that operand uses wb_data.
- Hazard: hazard=1 when in_valid=1, the current ID/EX holds out_valid=1 with control_out==LOAD_OPCODE and dest_index_out!=0, and a used rs1 or rs2 equals dest_index_out.
- in_ready = !hazard || flush.
- ID/EX update per rising edge, in priority order:
  - reset: clear.
  - flush: load a bubble (all fields 0, out_valid 0).
  - hazard: load a bubble; instr is not consumed and fetch holds it.
  - in_valid: load the decoded fields; out_valid=1 unless the opcode is undefined.
  - otherwise: load a bubble.
- Latency: an instruction accepted at edge N is visible on the outputs after edge N. A load-use pair costs exactly one bubble cycle.
- stall_count increments on each edge where hazard=1 and flush=0, and holds at 16'hFFFF.
- Flush and hazard in the same cycle: flush wins, no stall is counted, and the instruction is dropped.

Test Plan:
- Reset for 2 cycles, then ADD rd=2 rs1=0 rs2=0 -> control_out=00010, dest=2, reg1=reg2=0, out_valid=1, reg_write_en=1.
- wb_en=1 wb_index=3 wb_data=10 in the same cycle as SUB rd=2 rs1=3 rs2=4 (R4 previously written 3) -> reg1_data=10 (bypass), reg2_data=3, immediate passed through.
- LOAD rd=5 followed by ADD rs1=5 -> one bubble (out_valid=0, control 0), in_ready=0 for one cycle, ADD issues on the next edge, stall_count=1.
- LOAD rd=5 followed by JMP using field rs1=5 -> no stall, since JMP does not use rs1.
- Assert flush with a valid ADD and a concurrent hazard -> bubble, in_ready=1, stall_count unchanged.
- wb_en=1 wb_index=0 wb_data=16'hFFFF, then read R0 -> 0; undefined opcode 11111 -> out_valid=0, reg_write_en=0.
